// File: rtl/i2c_codec_target.sv
// Write-only I2C target for a codec: 7-bit address byte, then a 7-bit register address and 9 data bits over two bytes.
// ACK drives SDA about SYNC_STAGES+1 clk after the SCL fall; the write commits when the third ACK starts; there is no backpressure.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic [8:0] l_vol,
  output logic [8:0] r_vol,
  output logic       active,
  output logic [7:0] wr_count
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, scl, sda;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic                   byte_done, commit, ack_state, rx_state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic [6:0]             reg_addr;
  logic                   data_hi;
  logic [8:0]             regs [0:9];

  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  // Synchronizers reset to an idle (high) bus so no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sdat_in};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign commit    = (state == BYTE2) && byte_done;
  assign ack_state = (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
  assign rx_state  = (state == ADDR) || (state == BYTE1) || (state == BYTE2);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = ADDR;
    else if (stop_det) state_nxt = IDLE;
    else if (scl_fall) begin
      case (state)
        ADDR:    if (byte_done) state_nxt = (shift == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
        ACK_A:   state_nxt = BYTE1;
        BYTE1:   if (byte_done) state_nxt = ACK_1;
        ACK_1:   state_nxt = BYTE2;
        BYTE2:   if (byte_done) state_nxt = ACK_2;
        ACK_2:   state_nxt = IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    i2c_sdat_oe = ack_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shift    <= '0;
      reg_addr <= '0;
      data_hi  <= 1'b0;
    end else begin
      if (start_det || (scl_fall && ack_state)) begin
        bit_cnt <= '0;
      end else if (scl_rise && rx_state && (bit_cnt != 4'd8)) begin
        shift   <= {shift[6:0], sda};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if ((state == BYTE1) && byte_done) begin
        reg_addr <= shift[7:1];
        data_hi  <= shift[0];
      end
    end
  end

  // Commit lands on the same edge that moves the FSM into ACK_2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_count  <= '0;
      for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_addr  <= reg_addr;
        wr_data  <= {data_hi, shift};
        wr_count <= wr_count + 8'd1;
        if (reg_addr == 7'h0F) begin
          for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
        end else if (reg_addr <= 7'd9) begin
          regs[reg_addr[3:0]] <= {data_hi, shift};
        end
      end
    end
  end

  assign l_vol  = regs[2];
  assign r_vol  = regs[3];
  assign active = regs[9][0];

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master, table of write transactions plus hand-written abort/reset sequences.
module tb_i2c_codec_target;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset, scl_m, sda_m, i2c_sdat_in;
  logic       i2c_sdat_oe, wr_strobe, active;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, l_vol, r_vol;
  logic [7:0] wr_count;

  always #5 clk = ~clk;
  assign i2c_sdat_in = sda_m & ~i2c_sdat_oe;

  i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl_m), .i2c_sdat_in(i2c_sdat_in),
    .i2c_sdat_oe(i2c_sdat_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .l_vol(l_vol), .r_vol(r_vol), .active(active),
    .wr_count(wr_count)
  );

  typedef struct {
    logic [7:0] dev, rb, db;
    logic [2:0] ack;
    logic       strobe;
    logic [8:0] l, r;
    logic       act;
    logic [7:0] cnt;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] sb_q[$];
  logic [15:0] sb_e;
  int          n_checks = 0, n_pass = 0, strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: each strobe consumes the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_wr_addr", 32'(wr_addr), 32'(sb_e[15:9]));
        check("sb_wr_data", 32'(wr_data), 32'(sb_e[8:0]));
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic ack_bit(output logic ack);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = i2c_sdat_oe; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(ack);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic push_write(input logic [7:0] rb, input logic [7:0] db);
    sb_q.push_back({rb[7:1], rb[0], db});
  endtask

  initial begin
    logic a0, a1, a2, a3;
    int   s0;

    vecs[0] = '{8'h34, 8'h04, 8'h39, 3'b111, 1'b1, 9'h039, 9'h079, 1'b0, 8'd1};
    vecs[1] = '{8'h36, 8'h04, 8'h39, 3'b000, 1'b0, 9'h039, 9'h079, 1'b0, 8'd1};
    vecs[2] = '{8'h35, 8'h06, 8'h55, 3'b000, 1'b0, 9'h039, 9'h079, 1'b0, 8'd1};
    vecs[3] = '{8'h34, 8'h07, 8'h23, 3'b111, 1'b1, 9'h039, 9'h123, 1'b0, 8'd2};
    vecs[4] = '{8'h34, 8'h12, 8'h01, 3'b111, 1'b1, 9'h039, 9'h123, 1'b1, 8'd3};
    vecs[5] = '{8'h34, 8'h20, 8'hAA, 3'b111, 1'b1, 9'h039, 9'h123, 1'b1, 8'd4};
    vecs[6] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1'b1, 9'h079, 9'h079, 1'b0, 8'd5};
    vecs[7] = '{8'h34, 8'h13, 8'hFE, 3'b111, 1'b1, 9'h079, 9'h079, 1'b0, 8'd6};

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_oe", 32'(i2c_sdat_oe), 0);
    check("rst_strobe", 32'(wr_strobe), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_l_vol", 32'(l_vol), 32'h079);
    check("rst_r_vol", 32'(r_vol), 32'h079);
    check("rst_active", 32'(active), 0);
    check("rst_wr_count", 32'(wr_count), 0);

    foreach (vecs[k]) begin
      s0 = strobe_cnt;
      if (vecs[k].strobe) push_write(vecs[k].rb, vecs[k].db);
      i2c_start();
      send_byte(vecs[k].dev, a0);
      send_byte(vecs[k].rb, a1);
      send_byte(vecs[k].db, a2);
      i2c_stop();
      wait_q();
      check($sformatf("v%0d_acks", k), 32'({a0, a1, a2}), 32'(vecs[k].ack));
      check($sformatf("v%0d_strobes", k), 32'(strobe_cnt - s0), 32'(vecs[k].strobe));
      check($sformatf("v%0d_l_vol", k), 32'(l_vol), 32'(vecs[k].l));
      check($sformatf("v%0d_r_vol", k), 32'(r_vol), 32'(vecs[k].r));
      check($sformatf("v%0d_active", k), 32'(active), 32'(vecs[k].act));
      check($sformatf("v%0d_wr_count", k), 32'(wr_count), 32'(vecs[k].cnt));
    end

    // Repeated START after the register byte aborts, then a full write follows.
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h12, a1);
    i2c_start();
    check("abort_oe", 32'(i2c_sdat_oe), 0);
    check("abort_strobes", 32'(strobe_cnt - s0), 0);
    check("abort_wr_count", 32'(wr_count), 6);
    push_write(8'h12, 8'h01);
    send_byte(8'h34, a0);
    send_byte(8'h12, a1);
    send_byte(8'h01, a2);
    i2c_stop();
    wait_q();
    check("rs_acks", 32'({a0, a1, a2}), 32'b111);
    check("rs_active", 32'(active), 1);
    check("rs_wr_count", 32'(wr_count), 7);

    // A fourth byte must be NACKed and not counted again.
    s0 = strobe_cnt;
    push_write(8'h04, 8'h11);
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h04, a1);
    send_byte(8'h11, a2);
    send_byte(8'hFF, a3);
    i2c_stop();
    wait_q();
    check("b4_acks", 32'({a0, a1, a2, a3}), 32'b1110);
    check("b4_strobes", 32'(strobe_cnt - s0), 1);
    check("b4_wr_count", 32'(wr_count), 8);
    check("b4_l_vol", 32'(l_vol), 32'h011);

    // Reset in the middle of the data byte.
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h04, a1);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_oe", 32'(i2c_sdat_oe), 0);
    check("mid_rst_l_vol", 32'(l_vol), 32'h079);
    check("mid_rst_wr_count", 32'(wr_count), 0);
    check("mid_rst_wr_data", 32'(wr_data), 0);
    for (int i = 3; i >= 0; i--) send_bit(i[0]);
    ack_bit(a2);
    i2c_stop();
    wait_q();
    check("mid_rst_ack", 32'(a2), 0);
    check("mid_rst_strobes", 32'(strobe_cnt - s0), 0);
    push_write(8'h06, 8'h42);
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h06, a1);
    send_byte(8'h42, a2);
    i2c_stop();
    wait_q();
    check("post_rst_acks", 32'({a0, a1, a2}), 32'b111);
    check("post_rst_r_vol", 32'(r_vol), 32'h042);
    check("post_rst_wr_count", 32'(wr_count), 1);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
